// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and helpers for the alarm controller.
//   state_t  - FSM state encodings (codes 5-7 are illegal)
//   EVT_MAX  - saturation value of the alarm event counter
//   trig()   - alarm trigger term, motion or door open
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_t;

    localparam logic [3:0] EVT_MAX = 4'd15;

    // inP = 1 means door closed, so an open door is ~inP.
    function automatic logic trig(input logic in_m, input logic in_p);
        return in_m | ~in_p;
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// alarm_timer: loadable down-counter used for the exit, entry and siren delays.
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high; clears the count
//   load     - load load_val this cycle (wins over decrement)
//   load_val - value to load
//   zero     - count is 0
// The count holds at 0 and never wraps.
module alarm_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: per-zone home alarm sequencer.
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high
//   arm_req      - keypad arm command (level)
//   disarm_req   - valid-code disarm command (level), highest priority
//   inM          - motion sensor, 1 = motion
//   inP          - door sensor, 1 = closed
//   siren        - alarm sounder, on only in ALARM
//   armed        - 1 in ARMED, ENTRY or ALARM
//   state        - current state encoding
//   alarm_events - saturating count of ALARM entries
// Outputs are decoded from the registered state only.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int EXIT_DLY  = 8,
    parameter int ENTRY_DLY = 6,
    parameter int SIREN_CYC = 10,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm_req,
    input  logic       disarm_req,
    input  logic       inM,
    input  logic       inP,
    output logic       siren,
    output logic       armed,
    output logic [2:0] state,
    output logic [3:0] alarm_events
);

    // Loading DLY-1 and exiting on zero gives exactly DLY cycles in the state.
    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DLY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);
    localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_CYC - 1);

    state_t           state_q, state_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             evt_inc;
    logic             evt_clr;
    logic [3:0]       evt_q;

    alarm_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_DISARMED;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        evt_inc  = 1'b0;
        evt_clr  = 1'b0;
        case (state_q)
            ST_DISARMED: begin
                if (arm_req && !disarm_req) begin
                    state_d  = ST_EXIT;
                    tmr_load = 1'b1;
                    tmr_val  = EXIT_LD;
                    evt_clr  = 1'b1;
                end
            end
            ST_EXIT: begin
                if (disarm_req)
                    state_d = ST_DISARMED;
                else if (tmr_zero)
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (disarm_req)
                    state_d = ST_DISARMED;
                else if (trig(inM, inP)) begin
                    // Open door takes the entry-delay path even with motion.
                    if (!inP) begin
                        state_d  = ST_ENTRY;
                        tmr_load = 1'b1;
                        tmr_val  = ENTRY_LD;
                    end else begin
                        state_d  = ST_ALARM;
                        tmr_load = 1'b1;
                        tmr_val  = SIREN_LD;
                        evt_inc  = 1'b1;
                    end
                end
            end
            ST_ENTRY: begin
                if (disarm_req)
                    state_d = ST_DISARMED;
                else if (tmr_zero) begin
                    state_d  = ST_ALARM;
                    tmr_load = 1'b1;
                    tmr_val  = SIREN_LD;
                    evt_inc  = 1'b1;
                end
            end
            ST_ALARM: begin
                if (disarm_req)
                    state_d = ST_DISARMED;
                else if (tmr_zero)
                    state_d = ST_ARMED;
            end
            default: state_d = ST_DISARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            evt_q <= '0;
        else if (evt_clr)
            evt_q <= '0;
        else if (evt_inc && evt_q != EVT_MAX)
            evt_q <= evt_q + 4'd1;
    end

    assign state        = state_q;
    assign siren        = (state_q == ST_ALARM);
    assign armed        = (state_q == ST_ARMED) || (state_q == ST_ENTRY) ||
                          (state_q == ST_ALARM);
    assign alarm_events = evt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: scoreboard bench for alarm_controller with
// EXIT_DLY=4, ENTRY_DLY=3, SIREN_CYC=5. Each scenario queues one stimulus
// vector and one expected output set per cycle, then plays them back.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arm_req = 1'b0;
    logic       disarm_req = 1'b0;
    logic       inM = 1'b0;
    logic       inP = 1'b1;
    logic       siren;
    logic       armed;
    logic [2:0] state;
    logic [3:0] alarm_events;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic rst;
        logic arm;
        logic dis;
        logic m;
        logic p;
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic       sir;
        logic       arm;
        logic [3:0] ev;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    alarm_controller #(
        .EXIT_DLY  (4),
        .ENTRY_DLY (3),
        .SIREN_CYC (5),
        .CNT_W     (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arm_req      (arm_req),
        .disarm_req   (disarm_req),
        .inM          (inM),
        .inP          (inP),
        .siren        (siren),
        .armed        (armed),
        .state        (state),
        .alarm_events (alarm_events)
    );

    always #5 clk = ~clk;

    // Queue one cycle: inputs to drive and the outputs required after that edge.
    task automatic add(input logic rst, input logic a, input logic d,
                       input logic m, input logic p,
                       input logic [2:0] st, input logic [3:0] ev);
        stim_t s;
        exp_t  e;
        s = '{rst: rst, arm: a, dis: d, m: m, p: p};
        e.st  = st;
        e.sir = (st == 3'd4);
        e.arm = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
        e.ev  = ev;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        reset      = s.rst;
        arm_req    = s.arm;
        disarm_req = s.dis;
        inM        = s.m;
        inP        = s.p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t got;
        add(1, 0, 0, 0, 1, 3'd0, 4'd0);
        add(0, 0, 0, 1, 0, 3'd0, 4'd0);   // sensors ignored when disarmed
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e   = exp_q.pop_front();
            got = '{st: state, sir: siren, arm: armed, ev: alarm_events};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset: got st=%0d siren=%b armed=%b ev=%0d, need st=%0d siren=%b armed=%b ev=%0d",
                         got.st, got.sir, got.arm, got.ev, e.st, e.sir, e.arm, e.ev);
            end
        end
    endtask

    task automatic test_exit_delay();
        exp_t e;
        exp_t got;
        add(0, 1, 0, 0, 1, 3'd1, 4'd0);
        add(0, 1, 0, 1, 0, 3'd1, 4'd0);   // arm held, sensors active: no effect
        for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 1, 3'd1, 4'd0);
        add(0, 0, 0, 0, 1, 3'd2, 4'd0);
        add(0, 0, 0, 0, 1, 3'd2, 4'd0);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e   = exp_q.pop_front();
            got = '{st: state, sir: siren, arm: armed, ev: alarm_events};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL exit_delay: got st=%0d siren=%b armed=%b ev=%0d, need st=%0d siren=%b armed=%b ev=%0d",
                         got.st, got.sir, got.arm, got.ev, e.st, e.sir, e.arm, e.ev);
            end
        end
    endtask

    task automatic test_entry_alarm();
        exp_t e;
        exp_t got;
        add(0, 0, 0, 0, 0, 3'd3, 4'd0);   // door opens
        add(0, 0, 0, 0, 1, 3'd3, 4'd0);   // door closing does not cancel
        add(0, 0, 0, 0, 1, 3'd3, 4'd0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 3'd4, 4'd1);
        add(0, 0, 0, 0, 1, 3'd2, 4'd1);   // auto re-arm
        add(0, 0, 0, 0, 1, 3'd2, 4'd1);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e   = exp_q.pop_front();
            got = '{st: state, sir: siren, arm: armed, ev: alarm_events};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL entry_alarm: got st=%0d siren=%b armed=%b ev=%0d, need st=%0d siren=%b armed=%b ev=%0d",
                         got.st, got.sir, got.arm, got.ev, e.st, e.sir, e.arm, e.ev);
            end
        end
    endtask

    task automatic test_motion_disarm();
        exp_t e;
        exp_t got;
        add(0, 0, 0, 1, 1, 3'd4, 4'd2);   // motion: straight to ALARM
        add(0, 0, 0, 0, 1, 3'd4, 4'd2);
        add(0, 0, 1, 0, 1, 3'd0, 4'd2);   // disarm in 2nd siren cycle
        add(0, 1, 1, 0, 1, 3'd0, 4'd2);   // arm+disarm together: disarm wins
        add(0, 1, 0, 0, 1, 3'd1, 4'd0);   // arm clears the event count
        add(0, 1, 1, 0, 1, 3'd0, 4'd0);   // disarm in 2nd EXIT cycle
        add(0, 0, 0, 0, 1, 3'd0, 4'd0);
        add(0, 1, 0, 0, 1, 3'd1, 4'd0);   // fresh arm gives a full exit delay
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 3'd1, 4'd0);
        add(0, 0, 0, 0, 1, 3'd2, 4'd0);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e   = exp_q.pop_front();
            got = '{st: state, sir: siren, arm: armed, ev: alarm_events};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL motion_disarm: got st=%0d siren=%b armed=%b ev=%0d, need st=%0d siren=%b armed=%b ev=%0d",
                         got.st, got.sir, got.arm, got.ev, e.st, e.sir, e.arm, e.ev);
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        exp_t got;
        logic [3:0] ev;
        // Starts in ARMED with 0 events; motion held through 17 alarms.
        for (int k = 1; k <= 17; k++) begin
            ev = (k > 15) ? 4'd15 : 4'(k);
            for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 1, 3'd4, ev);
            add(0, 0, 0, 1, 1, 3'd2, ev);
        end
        add(0, 0, 1, 0, 1, 3'd0, 4'd15);
        add(0, 1, 0, 0, 1, 3'd1, 4'd0);
        add(0, 0, 1, 0, 1, 3'd0, 4'd0);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e   = exp_q.pop_front();
            got = '{st: state, sir: siren, arm: armed, ev: alarm_events};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL saturate: got st=%0d siren=%b armed=%b ev=%0d, need st=%0d siren=%b armed=%b ev=%0d",
                         got.st, got.sir, got.arm, got.ev, e.st, e.sir, e.arm, e.ev);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        exp_t got;
        add(0, 1, 0, 0, 1, 3'd1, 4'd0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 3'd1, 4'd0);
        add(0, 0, 0, 0, 1, 3'd2, 4'd0);
        add(0, 0, 0, 0, 0, 3'd3, 4'd0);
        add(0, 0, 0, 0, 1, 3'd3, 4'd0);
        add(1, 0, 0, 0, 1, 3'd0, 4'd0);   // reset mid-ENTRY
        add(0, 0, 0, 0, 1, 3'd0, 4'd0);
        add(0, 1, 0, 0, 1, 3'd1, 4'd0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 3'd1, 4'd0);
        add(0, 0, 0, 0, 1, 3'd2, 4'd0);
        add(0, 0, 0, 1, 1, 3'd4, 4'd1);
        add(0, 0, 0, 1, 1, 3'd4, 4'd1);
        add(1, 0, 0, 1, 1, 3'd0, 4'd0);   // reset mid-ALARM
        add(0, 0, 0, 1, 1, 3'd0, 4'd0);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e   = exp_q.pop_front();
            got = '{st: state, sir: siren, arm: armed, ev: alarm_events};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid: got st=%0d siren=%b armed=%b ev=%0d, need st=%0d siren=%b armed=%b ev=%0d",
                         got.st, got.sir, got.arm, got.ev, e.st, e.sir, e.arm, e.ev);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_exit_delay();
        test_entry_alarm();
        test_motion_disarm();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Sequential controller for the home-alarm datapath, which uses the trigger equation L = A·M + A·P'.
- The armed term A becomes an FSM state, so the trigger is evaluated only while armed.
- Adds exit/entry delays, a timed siren, automatic re-arm and an event counter.
- Sits between the keypad/sensor inputs and the siren/LED outputs; one instance per protected zone.

Parameters:
- EXIT_DLY, 8, cycles spent in EXIT before ARMED (minimum 1)
- ENTRY_DLY, 6, cycles spent in ENTRY before ALARM (minimum 1)
- SIREN_CYC, 10, cycles the siren stays on in ALARM (minimum 1)
- CNT_W, 8, timer width; each delay parameter must be at most 2^CNT_W

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; one clock, sync/active-high fixed
- arm_req  in  1  keypad arm command, level sampled each cycle
- disarm_req  in  1  valid-code disarm command, level sampled each cycle
- inM  in  1  motion sensor, 1 = motion
- inP  in  1  door sensor, 1 = closed (P' = open)
- siren  out  1  alarm sounder
- armed  out  1  1 in ARMED, ENTRY or ALARM
- state  out  3  current state encoding
- alarm_events  out  4  saturating count of ALARM entries

Behaviour:
- Reset: state=DISARMED, timer=0, siren=0, armed=0, alarm_events=0. Reset applied mid-countdown or mid-ALARM aborts immediately to the same values.
- Outputs: Moore-decoded from registered state. An input sampled at edge n changes the outputs after edge n.
- trig = inM | ~inP, used only in ARMED.
- disarm_req has priority over every other condition in every state, including simultaneously with arm_req.
- Timer: a down-counter loaded with DLY-1 on entry to a timed state. It decrements each cycle, and the state exits when the timer is 0 at the edge. Each timed state therefore lasts exactly DLY cycles.
- Encodings: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4; codes 5-7 are illegal.
- DISARMED:
  - arm_req & ~disarm_req -> EXIT, load EXIT_DLY-1.
  - Sensors ignored.
- EXIT:
  - disarm_req -> DISARMED.
  - timer==0 -> ARMED.
  - Sensors ignored; armed=0.
  - arm_req ignored; the timer does not restart.
- ARMED:
  - disarm_req -> DISARMED.
  - else ~inP -> ENTRY, load ENTRY_DLY-1 (door has priority over motion).
  - else inM -> ALARM, load SIREN_CYC-1.
- ENTRY:
  - disarm_req -> DISARMED.
  - timer==0 -> ALARM, load SIREN_CYC-1.
  - Sensors ignored; a door closing does not cancel ENTRY.
- ALARM:
  - siren=1.
  - disarm_req -> DISARMED.
  - timer==0 -> ARMED (auto re-arm). If trig is still true, the next cycle follows the ARMED rules.
- alarm_events:
  - Increments by 1 on every transition into ALARM; saturates at 15.
  - Cleared on the DISARMED->EXIT transition.
- Illegal codes 5-7 -> DISARMED on the next edge with siren=0 (safe recovery).

Decomposition:
- Package alarm_pkg:
  - state enum and its encodings
  - constant EVT_MAX=15
  - trig function (inM | ~inP)
- Sub-module alarm_timer: CNT_W-bit loadable down-counter.
  - Ports: clk, reset, load, load_val, zero.
  - Holds at 0 and never wraps below 0.
- The FSM and the event counter stay in alarm_controller.

Test Plan (EXIT_DLY=4, ENTRY_DLY=3, SIREN_CYC=5):
- Reset, then 1-cycle arm_req with inP=1, inM=0 -> state=1 for exactly 4 cycles, then state=2, armed=1, siren=0.
- In ARMED, drop inP to 0 for 1 cycle and never disarm -> ENTRY for 3 cycles, then siren=1 for 5 cycles, then state=2; alarm_events=1.
- In ARMED, inM=1 with inP=1 -> ALARM on the next edge, with no entry delay; disarm_req in the 2nd siren cycle -> state=0, siren=0 after that edge.
- arm_req and disarm_req asserted together in DISARMED -> stays 0. In EXIT, disarm on the 2nd cycle -> state=0 and the timer is not reloaded.
- Hold inM=1 through 17 ALARM/re-arm cycles -> alarm_events saturates at 15. A later arm from DISARMED clears it to 0.
- Assert reset mid-ENTRY, and separately mid-ALARM -> next edge: state=0, siren=0, armed=0, alarm_events=0.
